// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request bus and ROM/RAM device bus of the memory bus controller.
// The controller uses the slave modport; the CPU/memory side uses master.
interface mem_bus_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [7:0]  rom_rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        bus_err;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, rom_rdata, ram_rdata,
        output cpu_rdata, cpu_ready, rom_addr, rom_en, ram_addr, ram_wdata,
        output ram_en, ram_we, bus_err
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, rom_rdata, ram_rdata,
        input  cpu_rdata, cpu_ready, rom_addr, rom_en, ram_addr, ram_wdata,
        input  ram_en, ram_we, bus_err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: ROM/RAM decode, per-region wait states, registered read data.
// Optional bus error pulse is built only when MEMCTL_BUSERR_EN is defined.
module mem_bus_ctrl #(
    parameter int ROM_WAIT = 0,
    parameter int RAM_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_nxt;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_is_read;
    logic        r_is_rom;
    logic [7:0]  r_rdata;
    logic        r_ready;
    logic        r_rom_en;
    logic        r_ram_en;
    logic        r_ram_we;

    logic        w_accept;
    logic        w_req_rom;
    logic        w_in_access_nxt;
    logic        w_cur_rom;
    logic        w_cur_read;
    logic        w_capture;
    logic        w_rom_en_nxt;
    logic        w_ram_en_nxt;
    logic        w_ram_we_nxt;

    assign w_accept  = (r_state == IDLE) && (bus.cpu_read || bus.cpu_write);
    assign w_req_rom = (bus.cpu_addr[15:8] == 8'h00);
    assign w_capture = (r_state == ACCESS) && (r_wait_cnt == 4'd0) && r_is_read;

    // Next state, wait count and next-cycle strobes; strobes are registered so they
    // follow the state register exactly and drop with it on reset.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_in_access_nxt = 1'b0;
        w_cur_rom       = r_is_rom;
        w_cur_read      = r_is_read;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = ACCESS;
                    w_wait_cnt_nxt  = w_req_rom ? ROM_WAIT_C : RAM_WAIT_C;
                    w_in_access_nxt = 1'b1;
                    w_cur_rom       = w_req_rom;
                    w_cur_read      = bus.cpu_read;
                end else begin
                    w_state_nxt     = IDLE;
                end
            end
            ACCESS: begin
                if (r_wait_cnt != 4'd0) begin
                    w_state_nxt     = ACCESS;
                    w_wait_cnt_nxt  = r_wait_cnt - 4'd1;
                    w_in_access_nxt = 1'b1;
                end else begin
                    w_state_nxt     = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = 4'd0;
            end
        endcase
        // A ROM write gets no strobe at all: the write is silently discarded.
        w_rom_en_nxt = w_in_access_nxt && w_cur_rom && w_cur_read;
        w_ram_en_nxt = w_in_access_nxt && !w_cur_rom;
        w_ram_we_nxt = w_in_access_nxt && !w_cur_rom && !w_cur_read;
    end

    // State register, wait counter and registered strobes/ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_rom_en   <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_rom_en   <= w_rom_en_nxt;
            r_ram_en   <= w_ram_en_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ready    <= (w_state_nxt == DONE);
        end
    end

    // Request latches; read wins when both request lines are high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
            r_is_read <= 1'b0;
            r_is_rom  <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= bus.cpu_addr;
            r_wdata   <= bus.cpu_wdata;
            r_is_read <= bus.cpu_read;
            r_is_rom  <= w_req_rom;
        end else begin
            r_addr    <= r_addr;
            r_wdata   <= r_wdata;
            r_is_read <= r_is_read;
            r_is_rom  <= r_is_rom;
        end
    end

    // Read data capture on the last ACCESS cycle; holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 8'h00;
        end else if (w_capture) begin
            r_rdata <= r_is_rom ? bus.rom_rdata : bus.ram_rdata;
        end else begin
            r_rdata <= r_rdata;
        end
    end

`ifdef MEMCTL_BUSERR_EN
    logic r_err_flag;
    logic r_bus_err;

    // Flag ROM writes and read+write collisions at acceptance; pulse with ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_flag <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err_flag <= (bus.cpu_read && bus.cpu_write) ||
                              (!bus.cpu_read && bus.cpu_write && w_req_rom);
            end else begin
                r_err_flag <= r_err_flag;
            end
            r_bus_err <= (w_state_nxt == DONE) && r_err_flag;
        end
    end

    assign bus.bus_err = r_bus_err;
`else
    assign bus.bus_err = 1'b0;
`endif

    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_ready = r_ready;
    assign bus.rom_addr  = r_addr[7:0];
    assign bus.rom_en    = r_rom_en;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl with ROM/RAM models and hand-computed expectations.
module tb_mem_bus_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

`ifdef MEMCTL_BUSERR_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl #(.ROM_WAIT(0), .RAM_WAIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom_mem [0:255];
    logic [7:0] ram_mem [0:65535];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rom_rdata = bus.rom_en ? rom_mem[bus.rom_addr] : 8'h00;
    assign bus.ram_rdata = (bus.ram_en && !bus.ram_we) ? ram_mem[bus.ram_addr] : 8'h00;

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [7:0] wd, output int cyc, output int n_rom,
                              output int n_ram, output int n_we, output int n_err,
                              output logic [15:0] ram_a);
        bit done;
        done = 1'b0;
        cyc = 0; n_rom = 0; n_ram = 0; n_we = 0; n_err = 0; ram_a = 16'h0000;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(posedge clk); #1;
            if (bus.rom_en) n_rom++;
            if (bus.ram_en) begin n_ram++; ram_a = bus.ram_addr; end
            if (bus.ram_we) n_we++;
            if (bus.bus_err) n_err++;
            if (bus.cpu_ready) begin cyc = i; done = 1'b1; end
        end
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        if (!done) check_val("timeout", 16'd0, 16'd1);
        @(posedge clk); #1;
        check_val("ready_drop", 16'(bus.cpu_ready), 16'd0);
    endtask

    initial begin
        int cyc, n_rom, n_ram, n_we, n_err, n_rdy;
        logic [15:0] ram_a;
        logic [5:0]  rdy_pat;

        n_vec = 0;
        n_miss = 0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        rom_mem[16]     = 8'hA5;
        rom_mem[255]    = 8'h5A;
        rom_mem[5]      = 8'h11;
        ram_mem[16'h0100] = 8'hC3;
        ram_mem[16'hFFFF] = 8'hE7;

        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdata", 16'(bus.cpu_rdata), 16'h0000);
        check_val("rst_strobes", {12'h000, bus.cpu_ready, bus.rom_en, bus.ram_en, bus.ram_we}, 16'h0000);
        check_val("rst_addr", bus.ram_addr, 16'h0000);
        check_val("rst_err", 16'(bus.bus_err), 16'h0000);
        reset = 1'b0;

        // ROM read, zero wait states
        run_access(1'b1, 1'b0, 16'h0010, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("rom_rd_cyc", 16'(cyc), 16'd2);
        check_val("rom_rd_en", 16'(n_rom), 16'd1);
        check_val("rom_rd_ramen", 16'(n_ram), 16'd0);
        check_val("rom_rd_data", 16'(bus.cpu_rdata), 16'h00A5);

        // RAM write then read back
        run_access(1'b0, 1'b1, 16'h0200, 8'h3C, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("ram_wr_cyc", 16'(cyc), 16'd3);
        check_val("ram_wr_en", 16'(n_ram), 16'd2);
        check_val("ram_wr_we", 16'(n_we), 16'd2);
        check_val("ram_wr_keep", 16'(bus.cpu_rdata), 16'h00A5);
        check_val("ram_wr_mem", 16'(ram_mem[16'h0200]), 16'h003C);
        run_access(1'b1, 1'b0, 16'h0200, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("ram_rd_cyc", 16'(cyc), 16'd3);
        check_val("ram_rd_we", 16'(n_we), 16'd0);
        check_val("ram_rd_data", 16'(bus.cpu_rdata), 16'h003C);

        // Region boundaries
        run_access(1'b1, 1'b0, 16'h00FF, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("bnd_ff_rom", 16'(n_rom), 16'd1);
        check_val("bnd_ff_ram", 16'(n_ram), 16'd0);
        check_val("bnd_ff_data", 16'(bus.cpu_rdata), 16'h005A);
        run_access(1'b1, 1'b0, 16'h0100, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("bnd_100_rom", 16'(n_rom), 16'd0);
        check_val("bnd_100_ram", 16'(n_ram), 16'd2);
        check_val("bnd_100_addr", ram_a, 16'h0100);
        check_val("bnd_100_data", 16'(bus.cpu_rdata), 16'h00C3);
        run_access(1'b1, 1'b0, 16'hFFFF, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("bnd_ffff_addr", ram_a, 16'hFFFF);
        check_val("bnd_ffff_data", 16'(bus.cpu_rdata), 16'h00E7);

        // ROM write is discarded
        run_access(1'b0, 1'b1, 16'h0005, 8'h77, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("romwr_cyc", 16'(cyc), 16'd2);
        check_val("romwr_strobes", 16'(n_rom + n_ram + n_we), 16'd0);
        check_val("romwr_keep", 16'(bus.cpu_rdata), 16'h00E7);
        check_val("romwr_err", 16'(n_err), 16'(ERR_EXP));

        // Read and write together: read wins
        run_access(1'b1, 1'b1, 16'h0010, 8'h99, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("both_data", 16'(bus.cpu_rdata), 16'h00A5);
        check_val("both_err", 16'(n_err), 16'(ERR_EXP));
        run_access(1'b1, 1'b0, 16'h0010, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("clean_err", 16'(n_err), 16'd0);

        // Back-to-back reads with the request held high
        bus.cpu_read = 1'b1; bus.cpu_addr = 16'h00FF;
        rdy_pat = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rdy_pat[i] = bus.cpu_ready;
        end
        bus.cpu_read = 1'b0;
        check_val("b2b_ready", 16'(rdy_pat), 16'h0012);
        repeat (3) @(posedge clk);
        #1;

        // Async reset during the first ACCESS cycle of a RAM write
        bus.cpu_write = 1'b1; bus.cpu_addr = 16'h0300; bus.cpu_wdata = 8'h99;
        @(posedge clk); #1;
        check_val("mid_ram_en", {14'h0000, bus.ram_en, bus.ram_we}, 16'h0003);
        #2 reset = 1'b1;
        #1;
        check_val("mid_async", {13'h0000, bus.ram_en, bus.ram_we, bus.cpu_ready}, 16'h0000);
        bus.cpu_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ready || bus.ram_en) n_rdy++;
        end
        check_val("mid_no_ready", 16'(n_rdy), 16'd0);
        check_val("mid_mem", 16'(ram_mem[16'h0300]), 16'h0000);
        run_access(1'b1, 1'b0, 16'h0010, 8'h00, cyc, n_rom, n_ram, n_we, n_err, ram_a);
        check_val("post_rst_cyc", 16'(cyc), 16'd2);
        check_val("post_rst_data", 16'(bus.cpu_rdata), 16'h00A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory bus controller between the CPU core's memory request signals and the program ROM / data RAM devices.
- Decodes the 16-bit address into ROM (0x0000-0x00FF) or RAM (0x0100-0xFFFF).
- Sequences each access with per-region wait states, registers read data, and returns a one-cycle ready handshake to the CPU.
- Replaces the purely combinational tri-state ROM/RAM data mux with a timed, registered access path.

Parameters:
- ROM_WAIT, 0, extra ACCESS cycles for ROM reads (0-15).
- RAM_WAIT, 1, extra ACCESS cycles for RAM reads and writes (0-15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  16  access address
- cpu_wdata  in  8  write data
- cpu_read  in  1  read request, level, held until cpu_ready
- cpu_write  in  1  write request, level, held until cpu_ready
- cpu_rdata  out  8  registered read data
- cpu_ready  out  1  one-cycle access-complete pulse
- rom_addr  out  8  ROM address (cpu_addr[7:0] latched)
- rom_en  out  1  ROM read enable
- rom_rdata  in  8  ROM data, valid while rom_en high
- ram_addr  out  16  RAM address (latched)
- ram_wdata  out  8  RAM write data (latched)
- ram_en  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_rdata  in  8  RAM data, valid while ram_en high and ram_we low
- bus_err  out  1  error pulse; present only with MEMCTL_BUSERR_EN, otherwise tied 0

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: state IDLE, wait counter 0, all latches 0, and all outputs 0 (cpu_rdata 8'h00).
- Reset mid-access: rom_en, ram_en, ram_we and cpu_ready drop immediately; no ready is issued; the access is lost.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - At the edge where cpu_read|cpu_write is high, latch address, wdata, direction (read wins if both are high) and region.
  - Load the counter with ROM_WAIT or RAM_WAIT according to region, then go to ACCESS.
  - All strobes are low in IDLE.
- ACCESS, strobes decoded from the latched region and direction:
  - ROM read: rom_en=1.
  - RAM read: ram_en=1, ram_we=0.
  - RAM write: ram_en=1, ram_we=1 for every ACCESS cycle; address and data are stable throughout.
  - ROM write: no strobe asserted; the write is discarded.
- Counter:
  - Counter>0 at the edge: decrement and stay in ACCESS.
  - Counter==0 at the edge: on a read, capture rom_rdata or ram_rdata into cpu_rdata; go to DONE.
- DONE: cpu_ready=1 for exactly one cycle, strobes low; unconditional return to IDLE.
- Latency: request sampled at edge E0 → ACCESS cycles E0..E0+WAIT → cpu_ready high in the cycle after edge E0+WAIT+1. Total is WAIT+2 cycles from request to ready.
- CPU obligation: drop the request in the cycle after ready is seen. A request still high in IDLE starts a new access (back-to-back at a one-cycle bubble).
- cpu_rdata holds the last read value; writes and ROM-write discards never change it.
- Request changes during ACCESS/DONE are ignored (the access uses latched values).
- Region boundaries:
  - 0x00FF decodes as ROM, 0x0100 as RAM.
  - 0xFFFF decodes as RAM.
  - No address wrap is performed.

Optional Feature:
- MEMCTL_BUSERR_EN defined:
  - bus_err pulses high coincident with cpu_ready for a ROM-region write, and for an access where both cpu_read and cpu_write were high at acceptance (the read is still performed).
- Undefined: bus_err is constant 0 and no error detection logic is built; functional behaviour is otherwise identical.

Test Plan:
- Reset then ROM read: ROM_WAIT=0, ROM holds 8'hA5 at 0x0010; read 0x0010 → rom_en high 1 cycle, cpu_ready at cycle 2, cpu_rdata=8'hA5.
- RAM write then read: RAM_WAIT=1; write 8'h3C to 0x0200 → ram_en/ram_we high 2 cycles, ready at cycle 3; read 0x0200 → cpu_rdata=8'h3C, ready at cycle 3.
- Boundary decode: read 0x00FF → rom_en only; read 0x0100 → ram_en only, ram_addr=16'h0100.
- ROM write discard: write 8'h77 to 0x0005 → no rom_en/ram_en/ram_we, ready at cycle 2, cpu_rdata unchanged; with MEMCTL_BUSERR_EN, bus_err=1 with ready.
- Back-to-back: hold cpu_read high for two accesses → ready pulses separated by one IDLE cycle, each for one cycle.
- Async reset mid-access: assert reset during RAM write ACCESS cycle 1 → ram_en/ram_we fall without waiting for clk, no cpu_ready, state IDLE after release.
